// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-code width, the op-code encodings produced
// by the ALU control decoder, and the default datapath width.
package alu_pkg;

  localparam int unsigned ALU_CTRL_W = 3;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [ALU_CTRL_W-1:0] {
    ALU_AND  = 3'b000,
    ALU_XOR  = 3'b001,
    ALU_SLL  = 3'b010,
    ALU_ADD  = 3'b011,
    ALU_SUB  = 3'b100,
    ALU_MUL  = 3'b101,
    ALU_ADDI = 3'b110,
    ALU_SRAI = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_sequencer_mul_iter_step.sv
// mul_iter_step: one combinational iteration of the shift-add multiplier.
// Retires MUL_BPC multiplier bits per call.
//   acc_i / acc_o       running product (low WIDTH bits)
//   mcand_i / mcand_o   multiplicand, shifted left by MUL_BPC on output
//   mplier_i / mplier_o multiplier, shifted right by MUL_BPC on output
module mul_iter_step #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_BPC = 1
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] mplier_o
);

  logic [WIDTH-1:0] partial;

  // mcand * mplier[MUL_BPC-1:0] as a sum of shifted multiplicands
  always_comb begin
    partial = '0;
    for (int unsigned i = 0; i < MUL_BPC; i++) begin
      if (mplier_i[i]) begin
        partial = partial + (mcand_i << i);
      end
    end
    acc_o    = acc_i + partial;
    mcand_o  = mcand_i << MUL_BPC;
    mplier_o = mplier_i >> MUL_BPC;
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle ALU front end. Single-cycle ops complete one
// edge after accept; MUL iterates on a shift-add engine for MUL_STEPS edges.
//   clk_i      clock, rising edge
//   rst_i      asynchronous active-low reset
//   valid_i    request valid; accepted when ready_o & ~flush_i
//   ready_o    sequencer idle and able to accept
//   ALUCtrl_i  op code (alu_pkg::alu_op_e encoding)
//   data1_i    operand A
//   data2_i    operand B (immediate already extended)
//   flush_i    abort in-flight MUL / block acceptance
//   result_o   registered result, updated only on completion
//   done_o     one-cycle completion pulse
//   stall_o    combinational pipeline freeze request
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = DATA_W,
  parameter int unsigned MUL_BPC = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [ALU_CTRL_W-1:0] ALUCtrl_i,
  input  logic [WIDTH-1:0]      data1_i,
  input  logic [WIDTH-1:0]      data2_i,
  input  logic                  flush_i,
  output logic [WIDTH-1:0]      result_o,
  output logic                  done_o,
  output logic                  stall_o
);

  localparam int unsigned MUL_STEPS = WIDTH / MUL_BPC;
  localparam int unsigned CNT_W     = $clog2(MUL_STEPS + 1);
  localparam int unsigned SH_W      = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] STEPS_INIT = CNT_W'(MUL_STEPS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] acc_nxt, mcand_nxt, mplier_nxt;
  logic [WIDTH-1:0] alu_res;
  logic [SH_W-1:0]  shamt;
  logic             accept;
  alu_op_e          op;

  assign op    = alu_op_e'(ALUCtrl_i);
  assign shamt = data2_i[SH_W-1:0];

  mul_iter_step #(
    .WIDTH  (WIDTH),
    .MUL_BPC(MUL_BPC)
  ) u_mul_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .mplier_i(mplier_q),
    .acc_o   (acc_nxt),
    .mcand_o (mcand_nxt),
    .mplier_o(mplier_nxt)
  );

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_AND:            alu_res = data1_i & data2_i;
      ALU_XOR:            alu_res = data1_i ^ data2_i;
      ALU_SLL:            alu_res = data1_i << shamt;
      ALU_ADD, ALU_ADDI:  alu_res = data1_i + data2_i;
      ALU_SUB:            alu_res = data1_i - data2_i;
      ALU_SRAI:           alu_res = WIDTH'($signed(data1_i) >>> shamt);
      default:            alu_res = '0;
    endcase
  end

  assign accept  = valid_i & (state_q == ST_IDLE) & ~flush_i;
  assign ready_o = (state_q == ST_IDLE);
  assign stall_o = (state_q == ST_MUL) |
                   ((state_q == ST_IDLE) & valid_i & (op == ALU_MUL) & ~flush_i);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (op == ALU_MUL) begin
            acc_d    = '0;
            mcand_d  = data1_i;
            mplier_d = data2_i;
            cnt_d    = STEPS_INIT;
            state_d  = ST_MUL;
          end else begin
            result_d = alu_res;
            done_d   = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (flush_i) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          acc_d    = acc_nxt;
          mcand_d  = mcand_nxt;
          mplier_d = mplier_nxt;
          cnt_d    = cnt_q - CNT_ONE;
          // Final iteration: publish the accumulator as it is being written
          if (cnt_q == CNT_ONE) begin
            result_d = acc_nxt;
            done_d   = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign result_o = result_q;
  assign done_o   = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_XOR  = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_SUB  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam int unsigned STEPS  = 32;
  localparam int unsigned STEPS4 = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0;
  logic        flush = 1'b0;
  logic        ready, done, stall;
  logic [31:0] result;

  logic        valid4 = 1'b0;
  logic [2:0]  op4 = '0;
  logic [31:0] a4 = '0, b4 = '0;
  logic        ready4, done4, stall4;
  logic [31:0] result4;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  logic [31:0] last_res = '0;
  bit          mon_en = 1'b0;

  typedef struct {
    logic [31:0] res;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_sequencer dut (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid), .ready_o(ready),
    .ALUCtrl_i(op), .data1_i(a), .data2_i(b), .flush_i(flush),
    .result_o(result), .done_o(done), .stall_o(stall)
  );

  alu_sequencer #(.WIDTH(32), .MUL_BPC(4)) dut4 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid4), .ready_o(ready4),
    .ALUCtrl_i(op4), .data1_i(a4), .data2_i(b4), .flush_i(1'b0),
    .result_o(result4), .done_o(done4), .stall_o(stall4)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    case (o)
      3'd0: return x & y;
      3'd1: return x ^ y;
      3'd2: return x << y[4:0];
      3'd3, 3'd6: return x + y;
      3'd4: return x - y;
      3'd5: begin
        p = {32'd0, x} * {32'd0, y};
        return p[31:0];
      end
      default: return 32'($signed(x) >>> y[4:0]);
    endcase
  endfunction

  // Monitor: pops an expectation on every done pulse, checks value and cycle,
  // and otherwise checks that result_o holds the last completed value.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("result", result, e.res);
          check("done_cycle", cyc, e.due);
          last_res = e.res;
        end
      end else begin
        check("result_hold", result, last_res);
      end
    end
  end

  // Called right after a posedge. Presents the op, waits (bounded) for ready,
  // records the expectation and returns just after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit push, input logic [31:0] want, output int unsigned acc_cyc);
    int unsigned k;
    valid = 1'b1; op = o; a = x; b = y;
    k = 0;
    @(negedge clk);
    while (!ready && k < 100) begin
      check("stall_while_busy", {31'd0, stall}, 32'd1);
      k++;
      @(negedge clk);
    end
    if (!ready) check("accept_timeout", 32'd0, 32'd1);
    check("stall_at_accept", {31'd0, stall}, {31'd0, (o == OP_MUL)});
    acc_cyc = cyc;
    if (push && ready) sb.push_back('{want, cyc + ((o == OP_MUL) ? 1 + STEPS : 1)});
    @(posedge clk); #1;
    valid = 1'b0; op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int unsigned k = 0;
    while (sb.size() != 0 && k < 200) begin @(posedge clk); #1; k++; end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic mul4(input logic [31:0] x, input logic [31:0] y, input logic [31:0] want);
    int unsigned c0, k;
    valid4 = 1'b1; op4 = OP_MUL; a4 = x; b4 = y;
    @(negedge clk);
    check("bpc4_ready", {31'd0, ready4}, 32'd1);
    check("bpc4_stall", {31'd0, stall4}, 32'd1);
    c0 = cyc;
    @(posedge clk); #1;
    valid4 = 1'b0;
    k = 0;
    @(negedge clk);
    while (!done4 && k < 40) begin k++; @(negedge clk); end
    check("bpc4_done_cycle", cyc, c0 + 1 + STEPS4);
    check("bpc4_result", result4, want);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned ac, mul_acc, gap;
    logic [2:0]  o;
    logic [31:0] x, y;

    // Reset held with random activity on the inputs
    for (int i = 0; i < 5; i++) begin
      valid = 1'($urandom); op = 3'($urandom); a = $urandom; b = $urandom;
      @(negedge clk);
      check("rst_result", result, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd1);
    end
    valid = 1'b0;
    #1 check("rst_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;

    // Single-cycle ops back to back
    issue(OP_SUB, 32'd5, 32'd7, 1, 32'hFFFF_FFFE, ac);
    issue(3'b111, 32'h8000_0000, 32'd4, 1, 32'hF800_0000, ac);
    issue(OP_SLL, 32'd1, 32'd31, 1, 32'h8000_0000, ac);
    issue(OP_XOR, 32'h0000_F0F0, 32'h0000_FFFF, 1, 32'h0000_0F0F, ac);
    drain();
    idle(1);

    // MUL followed immediately by ADD, accepted in the MUL done cycle
    issue(OP_MUL, 32'd7, 32'd6, 1, 32'd42, mul_acc);
    issue(OP_ADD, 32'd3, 32'd4, 1, 32'd7, ac);
    check("add_in_done_cycle", ac, mul_acc + 1 + STEPS);
    drain();
    issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'd1, ac);
    drain();
    idle(1);

    // Flush at iteration 10 of a MUL: no completion, result unchanged
    issue(OP_MUL, 32'h1234, 32'h5678, 0, 32'd0, ac);
    idle(9);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_ready", {31'd0, ready}, 32'd1);
    check("flush_stall", {31'd0, stall}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;

    // Flush in IDLE blocks acceptance
    valid = 1'b1; op = OP_MUL; flush = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_noaccept", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;

    // Randomized traffic against the reference model
    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      issue(o, x, y, 1, ref_alu(o, x, y), ac);
      gap = $urandom_range(0, 2);
      idle(gap);
    end
    drain();
    idle(2);

    // MUL_BPC=4 build
    mul4(32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
    x = $urandom; y = $urandom;
    mul4(x, y, ref_alu(OP_MUL, x, y));

    // Asynchronous reset at iteration 3 of a MUL
    issue(OP_MUL, 32'd9, 32'd9, 0, 32'd0, ac);
    idle(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_result", result, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_ready", {31'd0, ready}, 32'd1);
    check("arst_stall", {31'd0, stall}, 32'd0);
    last_res = '0;
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(STEPS + 2);
    issue(OP_AND, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 1, 32'h0E0D_0E0F, ac);
    drain();
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
